// File: rtl/bank_readback_ctrl.sv
// Bank B readback sequencer: READ -> CAPT -> PRESENT per word, valid/ready out.
// Optional READBACK_CHKSUM_EN adds a running XOR of accepted words on chksum.
module bank_readback_ctrl #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int NWORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
`ifdef READBACK_CHKSUM_EN
  output logic [DW-1:0] chksum,
`endif
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(NWORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    PRESENT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          hs;

  assign hs = (state_q == PRESENT) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        data_d  = rd_data;
        last_d  = (idx_q == LAST);
        state_d = PRESENT;
      end
      PRESENT: begin
        if (hs) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_en     = (state_q == READ);
  assign rd_addr   = AW'(idx_q);
  assign out_valid = (state_q == PRESENT);
  assign out_data  = data_q;
  // last flag only means something alongside a presented word
  assign out_last  = last_q && (state_q == PRESENT);
  assign busy      = (state_q == READ) || (state_q == CAPT)
                  || (state_q == PRESENT);
  assign done      = (state_q == DONE);

`ifdef READBACK_CHKSUM_EN
  logic [DW-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if ((state_q == IDLE) && start) begin
      chk_d = '0;
    end else if (hs) begin
      chk_d = chk_q ^ data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chksum = chk_q;
`endif

endmodule

// File: tb/tb_bank_readback_ctrl.sv
// Scoreboard bench for bank_readback_ctrl (NWORDS=4 and NWORDS=1 instances).
// Checksum checks are included when READBACK_CHKSUM_EN is defined.
module tb_bank_readback_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start1;
  logic       rd_en, rd_en1;
  logic [2:0] rd_addr, rd_addr1;
  logic [7:0] rd_data, rd_data1;
  logic       out_valid, out_valid1;
  logic       out_ready, out_ready1;
  logic [7:0] out_data, out_data1;
  logic       out_last, out_last1;
  logic       busy, busy1;
  logic       done, done1;
`ifdef READBACK_CHKSUM_EN
  logic [7:0] chksum, chksum1;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] mem [0:7];
  logic [7:0] mem1 [0:7];
  logic [8:0] sbq [$];
  int rd_log [$];
  logic [2:0] addr_log [$];
  int hs_log [$];
  int done_log [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_readback_ctrl #(.DW(8), .AW(3), .NWORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
`ifdef READBACK_CHKSUM_EN
    .chksum(chksum),
`endif
    .busy(busy), .done(done)
  );

  bank_readback_ctrl #(.DW(8), .AW(3), .NWORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_last(out_last1),
`ifdef READBACK_CHKSUM_EN
    .chksum(chksum1),
`endif
    .busy(busy1), .done(done1)
  );

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (rd_en1) rd_data1 <= mem1[rd_addr1];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pop expected word on every handshake
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid_rd_excl", {31'd0, out_valid & rd_en}, 32'd0);
      if (rd_en) begin
        rd_log.push_back(cyc);
        addr_log.push_back(rd_addr);
      end
      if (done) done_log.push_back(cyc);
      if (out_valid && out_ready) begin
        hs_log.push_back(cyc);
        if (sbq.size() == 0) begin
          chk("unexpected_word", {23'd0, out_last, out_data}, 32'h1ff);
        end else begin
          chk("word", {23'd0, out_last, out_data}, {23'd0, sbq.pop_front()});
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    addr_log.delete();
    hs_log.delete();
    done_log.delete();
  endtask

  task automatic push_run();
    sbq.push_back({1'b0, 8'h11});
    sbq.push_back({1'b0, 8'h22});
    sbq.push_back({1'b0, 8'h33});
    sbq.push_back({1'b1, 8'h44});
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    next();
    start = 1'b0;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) next();
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (done_log.size() == 0 && n < 60) begin
      next();
      n++;
    end
    if (done_log.size() == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    repeat (3) next();
  endtask

  initial begin
    int t;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    for (int i = 4; i < 8; i++) mem[i] = 8'hee;
    mem1[0] = 8'ha5;
    for (int i = 1; i < 8; i++) mem1[i] = 8'h5a;
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    out_ready = 1'b1;
    out_ready1 = 1'b1;
    next();
    next();
    @(negedge clk);
    chk("rst_outs", {rd_en, rd_addr, out_valid, out_data, out_last, busy, done},
        32'd0);
    chk("rst_outs1", {out_valid1, out_data1, busy1, done1}, 32'd0);
    next();
    reset = 1'b0;
    next();

    // run 1: back-to-back, check timing relative to start cycle
    clear_logs();
    push_run();
    pulse_start(t);
`ifdef READBACK_CHKSUM_EN
    @(negedge clk);
    chk("chk_clear", {24'd0, chksum}, 32'd0);
`endif
    wait_done("run1");
    chk("run1_nrd", rd_log.size(), 4);
    chk("run1_nhs", hs_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      chk("run1_rd_cyc", rd_log[i], t + 1 + 3 * i);
      chk("run1_rd_addr", {29'd0, addr_log[i]}, i);
    end
    for (int i = 0; i < 4 && i < hs_log.size(); i++)
      chk("run1_valid_cyc", hs_log[i], t + 3 + 3 * i);
    chk("run1_ndone", done_log.size(), 1);
    if (done_log.size() > 0) chk("run1_done_cyc", done_log[0], t + 13);
    chk("run1_sb_empty", sbq.size(), 0);
`ifdef READBACK_CHKSUM_EN
    chk("chk_final", {24'd0, chksum}, 32'h44);
`endif

    // run 2: stall 5 cycles on word 2
    clear_logs();
    push_run();
    pulse_start(t);
`ifdef READBACK_CHKSUM_EN
    @(negedge clk);
    chk("chk_clear2", {24'd0, chksum}, 32'd0);
`endif
    wait_until(t + 9);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {24'd0, out_data}, 32'h33);
      chk("stall_no_rd", {31'd0, rd_en}, 32'd0);
      next();
    end
    out_ready = 1'b1;
    wait_done("run2");
    chk("run2_nhs", hs_log.size(), 4);
    chk("run2_ndone", done_log.size(), 1);
    if (done_log.size() > 0) chk("run2_done_cyc", done_log[0], t + 18);
    chk("run2_sb_empty", sbq.size(), 0);

    // run 3: reset during PRESENT of word 1, then restart
    clear_logs();
    push_run();
    pulse_start(t);
    wait_until(t + 6);
    reset = 1'b1;
    sbq.delete();
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_outs",
        {rd_en, rd_addr, out_valid, out_data, out_last, busy, done}, 32'd0);
    next();
    clear_logs();
    push_run();
    pulse_start(t);
    wait_done("run3");
    if (addr_log.size() > 0) chk("run3_addr0", {29'd0, addr_log[0]}, 32'd0);
    chk("run3_nhs", hs_log.size(), 4);
    chk("run3_ndone", done_log.size(), 1);

    // run 4: start pulses while busy and during DONE are ignored
    clear_logs();
    push_run();
    pulse_start(t);
    wait_until(t + 5);
    start = 1'b1;
    next();
    start = 1'b0;
    wait_until(t + 13);
    start = 1'b1;
    next();
    start = 1'b0;
    repeat (20) next();
    chk("run4_nrd", rd_log.size(), 4);
    chk("run4_nhs", hs_log.size(), 4);
    chk("run4_ndone", done_log.size(), 1);
    chk("run4_idle", {31'd0, busy}, 32'd0);

    // NWORDS=1 instance
    start1 = 1'b1;
    t = cyc;
    next();
    start1 = 1'b0;
    wait_until(t + 3);
    @(negedge clk);
    chk("n1_valid", {31'd0, out_valid1}, 32'd1);
    chk("n1_word", {23'd0, out_last1, out_data1}, 32'h1a5);
    next();
    @(negedge clk);
    chk("n1_done", {31'd0, done1}, 32'd1);
`ifdef READBACK_CHKSUM_EN
    chk("n1_chk", {24'd0, chksum1}, 32'ha5);
`endif
    next();
    @(negedge clk);
    chk("n1_done_pulse", {30'd0, done1, busy1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
